// File: rtl/completion_arbiter_if.sv
// Completion broadcast bundle: four functional-unit result ports plus the
// registered ROB write / forwarding outputs of the completion arbiter.
interface completion_arbiter_if #(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int NUM_UNITS  = 4
);
  logic [NUM_UNITS-1:0]                 unitValid_i;
  logic [NUM_UNITS-1:0][ROBsizeLog-1:0] unitTag_i;
  logic [NUM_UNITS-1:0][64:0]           unitVal_i;
  logic [NUM_UNITS-1:0]                 unitReady_o;
  logic                                 completionStall_i;
  logic                                 flush_i;
  logic                                 completionValid_o;
  logic [ROBsizeLog-1:0]                completionTag_o;
  logic [64:0]                          completionVal_o;
  logic [NUM_UNITS-1:0]                 grant_o;
  logic                                 busy_o;

  // Functional units, ROB and branch recovery side.
  modport master (
    output unitValid_i, unitTag_i, unitVal_i, completionStall_i, flush_i,
    input  unitReady_o, completionValid_o, completionTag_o, completionVal_o,
           grant_o, busy_o
  );

  // Arbiter side.
  modport slave (
    input  unitValid_i, unitTag_i, unitVal_i, completionStall_i, flush_i,
    output unitReady_o, completionValid_o, completionTag_o, completionVal_o,
           grant_o, busy_o
  );
endinterface

// File: rtl/completion_arbiter.sv
// Round-robin arbiter sharing one registered completion broadcast among four
// functional units, each fronted by a one-entry valid/ready result buffer.
module completion_arbiter #(
  parameter int ROBsize    = 8,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int NUM_UNITS  = 4
) (
  input logic           clk_i,
  input logic           reset_i,
  completion_arbiter_if.slave bus
);
  typedef logic [ROBsizeLog-1:0] tag_t;
  typedef logic [64:0]           val_t;

  logic [NUM_UNITS-1:0] full_q;
  tag_t                 tag_q [NUM_UNITS];
  val_t                 val_q [NUM_UNITS];
  logic [1:0]           rr_ptr_q;

  logic                 comp_valid_q;
  tag_t                 comp_tag_q;
  val_t                 comp_val_q;

  logic [NUM_UNITS-1:0] grant;
  logic                 grant_found;
  logic [1:0]           grant_idx;
  logic [1:0]           probe_idx;
  logic [NUM_UNITS-1:0] ready;
  logic [NUM_UNITS-1:0] accept;

  // Search starts at the round-robin pointer; the first full buffer wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    grant       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    probe_idx   = '0;
    if (!bus.completionStall_i && !bus.flush_i) begin
      for (int off = 0; off < NUM_UNITS; off++) begin
        probe_idx = rr_ptr_q + 2'(off);
        if (full_q[probe_idx] && !grant_found) begin
          grant_found = 1'b1;
          grant_idx   = probe_idx;
        end
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  // A buffer being drained this cycle can take a new result on the same edge.
  assign ready  = ~full_q | grant;
  assign accept = bus.unitValid_i & ready & {NUM_UNITS{~bus.flush_i}};

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      full_q       <= '0;
      rr_ptr_q     <= '0;
      comp_valid_q <= 1'b0;
      comp_tag_q   <= '0;
      comp_val_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (bus.flush_i)     full_q[i] <= 1'b0;
        else if (accept[i])  full_q[i] <= (bus.unitTag_i[i] != '0);
        else if (grant[i])   full_q[i] <= 1'b0;
      end
      comp_valid_q <= grant_found;
      if (grant_found) begin
        comp_tag_q <= tag_q[grant_idx];
        comp_val_q <= val_q[grant_idx];
        rr_ptr_q   <= grant_idx + 2'd1;
      end
    end
  end

  // Tag-0 results complete the handshake but are never stored.
  always_ff @(posedge clk_i) begin
    // NOTE: payload storage has no reset; full_q alone qualifies its contents.
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (accept[i] && bus.unitTag_i[i] != '0) begin
        tag_q[i] <= bus.unitTag_i[i];
        val_q[i] <= bus.unitVal_i[i];
      end
    end
  end

  assign bus.unitReady_o       = ready;
  assign bus.grant_o           = grant;
  assign bus.completionValid_o = comp_valid_q;
  assign bus.completionTag_o   = comp_tag_q;
  assign bus.completionVal_o   = comp_val_q;
  assign bus.busy_o            = (|full_q) | comp_valid_q;
endmodule
